// File: rtl/glenn_timer_pkg.sv
// Shared constants for the record/transmit scheduler.
// Prescaler width is derived per instance from CLK_PER_SEC via pre_w().
package glenn_timer_pkg;

    localparam int DEF_REC_PERIOD_C = 60;
    localparam int DEF_TX_COUNT_C   = 5;

    // A 1 Hz clock still gets a 1-bit prescaler so the datapath shape never changes.
    function automatic int pre_w(input int clk_per_sec);
        return (clk_per_sec > 1) ? $clog2(clk_per_sec) : 1;
    endfunction

endpackage

// File: rtl/glenn_mod_counter.sv
// Modulo counter 0..in_Term with enable and synchronous clear.
// out_Wrap flags the enabled cycle in which the count rolls back to 0.
module glenn_mod_counter #(
    parameter int W = 8
) (
    input  logic         in_Clk,
    input  logic         in_Rst_n,
    input  logic         in_En,
    input  logic         in_Clr,
    input  logic [W-1:0] in_Term,
    output logic [W-1:0] out_Count,
    output logic         out_Wrap
);

    assign out_Wrap = in_En && (out_Count == in_Term);

    always_ff @(posedge in_Clk) begin
        if (!in_Rst_n)
            out_Count <= '0;
        else if (in_Clr)
            out_Count <= '0;
        else if (in_En)
            out_Count <= (out_Count == in_Term) ? '0 : out_Count + 1'b1;
    end

endmodule

// File: rtl/glenn_sched_timer.sv
// Record/transmit scheduler: prescaler -> seconds -> records chain,
// with runtime-loadable periods and a pending/ack handshake to the transmitter.
module glenn_sched_timer
    import glenn_timer_pkg::*;
#(
    parameter int CLK_PER_SEC    = 1,
    parameter int SEC_W          = 8,
    parameter int REC_W          = 4,
    parameter int DEF_REC_PERIOD = DEF_REC_PERIOD_C,
    parameter int DEF_TX_COUNT   = DEF_TX_COUNT_C
) (
    input  logic             in_Clk,
    input  logic             in_Rst_n,
    input  logic             in_Enable,
    input  logic             in_Clear,
    input  logic             in_Load,
    input  logic [SEC_W-1:0] in_RecPeriod,
    input  logic [REC_W-1:0] in_TxCount,
    input  logic             in_TxAck,
    output logic             out_RecordPulse,
    output logic             out_TxPulse,
    output logic             out_TxPending,
    output logic             out_TxOverrun,
    output logic             out_CfgErr,
    output logic [SEC_W-1:0] out_SecCount,
    output logic [REC_W-1:0] out_RecCount
);

    localparam int               PRE_W    = pre_w(CLK_PER_SEC);
    localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(CLK_PER_SEC - 1);

    logic [SEC_W-1:0] rec_period;
    logic [REC_W-1:0] tx_count;
    logic [PRE_W-1:0] pre_count;
    logic             tick, rec_evt, tx_evt;
    logic             load_ok, restart, flag_clr;

    assign load_ok  = in_Load && (in_RecPeriod != '0) && (in_TxCount != '0);
    assign restart  = load_ok || in_Clear;
    // A valid load restarts counting but must not drop an outstanding transmit.
    assign flag_clr = in_Clear && !load_ok;

    glenn_mod_counter #(.W(PRE_W)) u_pre (
        .in_Clk(in_Clk), .in_Rst_n(in_Rst_n), .in_En(in_Enable), .in_Clr(restart),
        .in_Term(PRE_TERM), .out_Count(pre_count), .out_Wrap(tick)
    );

    glenn_mod_counter #(.W(SEC_W)) u_sec (
        .in_Clk(in_Clk), .in_Rst_n(in_Rst_n), .in_En(tick), .in_Clr(restart),
        .in_Term(rec_period - 1'b1), .out_Count(out_SecCount), .out_Wrap(rec_evt)
    );

    glenn_mod_counter #(.W(REC_W)) u_rec (
        .in_Clk(in_Clk), .in_Rst_n(in_Rst_n), .in_En(rec_evt), .in_Clr(restart),
        .in_Term(tx_count - 1'b1), .out_Count(out_RecCount), .out_Wrap(tx_evt)
    );

    always_ff @(posedge in_Clk) begin
        if (!in_Rst_n) begin
            rec_period      <= SEC_W'(DEF_REC_PERIOD);
            tx_count        <= REC_W'(DEF_TX_COUNT);
            out_RecordPulse <= 1'b0;
            out_TxPulse     <= 1'b0;
            out_TxPending   <= 1'b0;
            out_TxOverrun   <= 1'b0;
            out_CfgErr      <= 1'b0;
        end else begin
            if (load_ok) begin
                rec_period <= in_RecPeriod;
                tx_count   <= in_TxCount;
            end
            out_CfgErr      <= in_Load && !load_ok;
            out_RecordPulse <= rec_evt && !restart;
            out_TxPulse     <= tx_evt && !restart;

            if (flag_clr) begin
                out_TxPending <= 1'b0;
                out_TxOverrun <= 1'b0;
            end else if (tx_evt && !restart) begin
                // An ack arriving with the new event counts as servicing the old one.
                out_TxPending <= 1'b1;
                if (out_TxPending && !in_TxAck)
                    out_TxOverrun <= 1'b1;
            end else if (in_TxAck) begin
                out_TxPending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_glenn_sched_timer.sv
// Directed bench: u_a runs at 1 Hz with default config, u_b runs with a 4x prescaler.
module tb_glenn_sched_timer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_en, a_clr, a_load, a_ack;
    logic [7:0] a_rp;
    logic [3:0] a_tc;
    logic       a_rpul, a_tpul, a_pend, a_ovr, a_cerr;
    logic [7:0] a_sec;
    logic [3:0] a_rec;
    logic       b_en, b_clr, b_load, b_ack;
    logic [7:0] b_rp;
    logic [3:0] b_tc;
    logic       b_rpul, b_tpul, b_pend, b_ovr, b_cerr;
    logic [7:0] b_sec;
    logic [3:0] b_rec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    glenn_sched_timer #(.CLK_PER_SEC(1)) u_a (
        .in_Clk(clk), .in_Rst_n(rst_n), .in_Enable(a_en), .in_Clear(a_clr),
        .in_Load(a_load), .in_RecPeriod(a_rp), .in_TxCount(a_tc), .in_TxAck(a_ack),
        .out_RecordPulse(a_rpul), .out_TxPulse(a_tpul), .out_TxPending(a_pend),
        .out_TxOverrun(a_ovr), .out_CfgErr(a_cerr), .out_SecCount(a_sec), .out_RecCount(a_rec)
    );

    glenn_sched_timer #(.CLK_PER_SEC(4)) u_b (
        .in_Clk(clk), .in_Rst_n(rst_n), .in_Enable(b_en), .in_Clear(b_clr),
        .in_Load(b_load), .in_RecPeriod(b_rp), .in_TxCount(b_tc), .in_TxAck(b_ack),
        .out_RecordPulse(b_rpul), .out_TxPulse(b_tpul), .out_TxPending(b_pend),
        .out_TxOverrun(b_ovr), .out_CfgErr(b_cerr), .out_SecCount(b_sec), .out_RecCount(b_rec)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_en = 0; a_clr = 0; a_load = 0; a_ack = 0; a_rp = 0; a_tc = 0;
        b_en = 0; b_clr = 0; b_load = 0; b_ack = 0; b_rp = 0; b_tc = 0;
        step(2);
        check("rst_a_outs", {a_rpul, a_tpul, a_pend, a_ovr, a_cerr, a_sec, a_rec}, 0);
        check("rst_b_outs", {b_rpul, b_tpul, b_pend, b_ovr, b_cerr, b_sec, b_rec}, 0);

        // u_b: prescaler 4, load period 3 s, 2 records per transmit
        rst_n = 1'b1;
        b_en = 1; b_load = 1; b_rp = 8'd3; b_tc = 4'd2;
        step(1);
        b_load = 0;
        check("b_load_cfgerr", b_cerr, 0);
        check("b_load_sec", b_sec, 0);
        step(11);
        check("b_rec_pre12", b_rpul, 0);
        step(1);
        check("b_rec_at12", {b_rpul, b_tpul}, 2'b10);
        check("b_reccount1", b_rec, 1);
        step(11);
        check("b_rec_pre24", b_rpul, 0);
        step(1);
        check("b_tx_at24", {b_rpul, b_tpul, b_pend, b_ovr}, 4'b1110);
        step(1);
        check("b_tx_oneshot", {b_rpul, b_tpul}, 2'b00);
        step(23);
        check("b_tx_2nd_ovr", {b_tpul, b_pend, b_ovr}, 3'b111);
        step(5);
        check("b_ovr_held", {b_pend, b_ovr}, 2'b11);
        b_clr = 1;
        step(1);
        b_clr = 0;
        check("b_clear_flags", {b_pend, b_ovr, b_sec, b_rec}, 0);
        step(24);
        check("b_tx_after_clr", {b_tpul, b_pend, b_ovr}, 3'b110);
        b_ack = 1;
        step(1);
        b_ack = 0;
        check("b_ack_clears", b_pend, 0);
        b_en = 0;

        // u_a: defaults, 1 Hz, enable from reset release
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        a_en = 1;
        step(59);
        check("a_pre60", {a_rpul, a_sec}, {1'b0, 8'd59});
        step(1);
        check("a_rec60", {a_rpul, a_tpul, a_sec, a_rec}, {2'b10, 8'd0, 4'd1});
        step(1);
        check("a_rec60_oneshot", a_rpul, 0);
        step(59);
        check("a_rec120", {a_rpul, a_rec}, {1'b1, 4'd2});
        step(179);
        check("a_pre300", {a_rpul, a_tpul, a_pend}, 3'b000);
        step(1);
        check("a_tx300", {a_rpul, a_tpul, a_pend, a_rec}, {3'b111, 4'd0});

        // freeze for 10 edges mid-period
        step(30);
        a_en = 0;
        step(10);
        check("a_frozen", {a_sec, a_rec, a_rpul}, {8'd30, 4'd0, 1'b0});
        a_en = 1;
        step(29);
        check("a_delayed_pre", {a_rpul, a_sec}, {1'b0, 8'd59});
        step(1);
        check("a_delayed_rec", a_rpul, 1);
        check("a_pend_kept", a_pend, 1);
        a_ack = 1;
        step(1);
        a_ack = 0;
        check("a_ack", a_pend, 0);

        // illegal load: ignored, CfgErr pulse
        a_load = 1; a_rp = 8'd0; a_tc = 4'd3;
        step(1);
        a_load = 0;
        check("a_cfgerr", {a_cerr, a_sec}, {1'b1, 8'd2});
        step(1);
        check("a_cfgerr_oneshot", {a_cerr, a_sec}, {1'b0, 8'd3});
        step(56);
        check("a_period_kept_pre", {a_rpul, a_sec}, {1'b0, 8'd59});
        step(1);
        check("a_period_kept", a_rpul, 1);

        // clear + load together: load wins
        a_clr = 1; a_load = 1; a_rp = 8'd5; a_tc = 4'd2;
        step(1);
        a_clr = 0; a_load = 0;
        check("a_loadwin_restart", {a_sec, a_rec, a_cerr}, 0);
        step(4);
        check("a_newper_pre", a_rpul, 0);
        step(1);
        check("a_newper_rec", {a_rpul, a_tpul}, 2'b10);
        step(5);
        check("a_newper_tx", {a_tpul, a_pend}, 2'b11);
        a_clr = 1; a_load = 1;
        step(1);
        a_clr = 0; a_load = 0;
        check("a_load_keeps_pend", {a_pend, a_sec}, {1'b1, 8'd0});

        // reset abandons state and restores defaults
        rst_n = 1'b0;
        step(1);
        check("a_rst_outs", {a_rpul, a_tpul, a_pend, a_ovr, a_cerr, a_sec, a_rec}, 0);
        rst_n = 1'b1;
        step(59);
        check("a_def_sec59", a_sec, 59);
        rst_n = 1'b0;
        step(1);
        check("a_rst_at59", {a_rpul, a_tpul, a_sec}, 0);
        rst_n = 1'b1;
        step(59);
        check("a_def_restored_pre", a_rpul, 0);
        step(1);
        check("a_def_restored", {a_rpul, a_sec, a_rec}, {1'b1, 8'd0, 4'd1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
